// File: rtl/mul_arbiter_pkg.sv
// rtl/mul_arbiter_pkg.sv - shared FSM encoding and width helper for mul_arbiter
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a derived width is always legal.
    function automatic int clog2w(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick from a request vector
// Ports:
//   req_i   : per-requester request bits
//   ptr_i   : highest-priority requester index for this pick
//   grant_o : index of the first set request at ptr_i, ptr_i+1, ... (wrapping)
//   valid_o : at least one request is set
module rr_select #(
    parameter int NUM_REQ = 3,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [PW-1:0]      grant_o,
    output logic               valid_o
);

    int idx;

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[idx]) begin
                grant_o = PW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one multiplier among requesters
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_i                  : per-requester level request
//   a_i, b_i               : packed operands, requester k at [k*2N +: 2N]
//   done_o, err_o          : one-cycle completion / timeout pulses
//   result_o               : product of the last completed operation (0 on timeout)
//   busy_o                 : an operation is in flight
//   mul_start_strb_o       : start strobe to the shared multiplier
//   mul_a_o, mul_b_o       : operands latched at grant
//   mul_done_strb_i        : multiplier completion strobe
//   mul_out_i              : multiplier result, valid with mul_done_strb_i
import mul_arbiter_pkg::*;

module mul_arbiter #(
    parameter int N       = 4,
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*2*N-1:0]   a_i,
    input  logic [NUM_REQ*2*N-1:0]   b_i,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic [2*N-1:0]           result_o,
    output logic                     busy_o,
    output logic                     mul_start_strb_o,
    output logic [2*N-1:0]           mul_a_o,
    output logic [2*N-1:0]           mul_b_o,
    input  logic                     mul_done_strb_i,
    input  logic [2*N-1:0]           mul_out_i
);

    localparam int W  = 2 * N;
    localparam int PW = clog2w(NUM_REQ);
    localparam int CW = clog2w(TIMEOUT + 1);

    state_e               state_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        ptr_d;
    logic [PW-1:0]        gnt_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 err_q;
    logic [W-1:0]         result_q;
    logic                 strb_q;
    logic [W-1:0]         mul_a_q;
    logic [W-1:0]         mul_b_q;

    logic [W-1:0]         a_arr [NUM_REQ];
    logic [W-1:0]         b_arr [NUM_REQ];
    logic [PW-1:0]        sel_idx;
    logic                 sel_valid;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign a_arr[k] = a_i[k*W +: W];
        assign b_arr[k] = b_i[k*W +: W];
    end

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_select (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (sel_idx),
        .valid_o (sel_valid)
    );

    // Priority moves to the requester just after the one being finished.
    assign ptr_d = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            strb_q   <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            // Pulse outputs default low; each is set for exactly one edge.
            done_q <= '0;
            err_q  <= 1'b0;
            strb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        gnt_q   <= sel_idx;
                        mul_a_q <= a_arr[sel_idx];
                        mul_b_q <= b_arr[sel_idx];
                        strb_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done_strb_i) begin
                        result_q       <= mul_out_i;
                        done_q[gnt_q]  <= 1'b1;
                        ptr_q          <= ptr_d;
                        state_q        <= ST_IDLE;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        result_q       <= '0;
                        done_q[gnt_q]  <= 1'b1;
                        err_q          <= 1'b1;
                        ptr_q          <= ptr_d;
                        state_q        <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done_o           = done_q;
    assign err_o            = err_q;
    assign result_o         = result_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign mul_start_strb_o = strb_q;
    assign mul_a_o          = mul_a_q;
    assign mul_b_o          = mul_b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter
module tb_mul_arbiter;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] req_i = 3'b000;
    logic [7:0] a_v [3];
    logic [7:0] b_v [3];
    logic [23:0] a_i;
    logic [23:0] b_i;
    logic [2:0] done_o;
    logic       err_o;
    logic [7:0] result_o;
    logic       busy_o;
    logic       mul_start_strb_o;
    logic [7:0] mul_a_o;
    logic [7:0] mul_b_o;
    logic       mul_done_strb_i = 1'b0;
    logic [7:0] mul_out_i = 8'h00;

    int total = 0;
    int bad = 0;
    int model_p = 0;
    int strb_cnt = 0;
    int mul_cnt = 0;
    bit mul_en = 1'b1;
    logic [7:0] mul_res;

    assign a_i = {a_v[2], a_v[1], a_v[0]};
    assign b_i = {b_v[2], b_v[1], b_v[0]};

    mul_arbiter #(.N(4), .NUM_REQ(3), .TIMEOUT(31)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .a_i              (a_i),
        .b_i              (b_i),
        .done_o           (done_o),
        .err_o            (err_o),
        .result_o         (result_o),
        .busy_o           (busy_o),
        .mul_start_strb_o (mul_start_strb_o),
        .mul_a_o          (mul_a_o),
        .mul_b_o          (mul_b_o),
        .mul_done_strb_i  (mul_done_strb_i),
        .mul_out_i        (mul_out_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_prod(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        int p;
        x = $signed(a);
        y = $signed(b);
        p = x * y;
        return p[7:0];
    endfunction

    function automatic int model_grant(input logic [2:0] r, input int p);
        for (int i = 0; i < 3; i++) begin
            if (r[(p + i) % 3]) return (p + i) % 3;
        end
        return -1;
    endfunction

    // Behavioural multiplier: answers 20 cycles after a start strobe; keeps
    // counting through reset so late strobes reach the DUT outside WAIT.
    always @(negedge clk) begin
        mul_done_strb_i = 1'b0;
        mul_out_i = 8'($urandom);
        if (mul_cnt > 0) begin
            mul_cnt = mul_cnt - 1;
            if (mul_cnt == 0) begin
                mul_done_strb_i = 1'b1;
                mul_out_i = mul_res;
            end
        end else if (mul_en && mul_start_strb_o) begin
            mul_cnt = 20;
            mul_res = model_prod(mul_a_o, mul_b_o);
        end
    end

    always @(negedge clk) begin
        if (mul_start_strb_o) strb_cnt = strb_cnt + 1;
        if (done_o != 3'b000) begin
            total = total + 1;
            if ($countones(done_o) != 1) begin
                bad = bad + 1;
                $display("FAIL onehot_done: done_o=%b required exactly one bit", done_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok, output bit strb_seen);
        ok = 1'b0;
        strb_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done_o != 3'b000) begin
                ok = 1'b1;
                strb_seen = mul_done_strb_i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 3'b000;
        step();
        step();
        rst_i = 1'b0;
        model_p = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total = total + 1;
        if ({done_o, err_o, busy_o, mul_start_strb_o} !== 6'b0) begin
            bad = bad + 1;
            $display("FAIL reset_flags: done=%b err=%b busy=%b strb=%b required 0", done_o, err_o, busy_o, mul_start_strb_o);
        end
        total = total + 1;
        if ({result_o, mul_a_o, mul_b_o} !== 24'h0) begin
            bad = bad + 1;
            $display("FAIL reset_data: result=%h a=%h b=%h required 0", result_o, mul_a_o, mul_b_o);
        end
    endtask

    task automatic test_single();
        bit ok;
        bit s;
        a_v[0] = 8'd3;
        b_v[0] = 8'd5;
        strb_cnt = 0;
        req_i = 3'b001;
        step();
        total = total + 1;
        if (mul_start_strb_o !== 1'b1 || busy_o !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL single_strobe_latency: strb=%b busy=%b required 1 1", mul_start_strb_o, busy_o);
        end
        wait_done(ok, s);
        total = total + 1;
        if (!ok || s !== 1'b1 || done_o !== 3'b001 || result_o !== 8'h0F || err_o !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL single_done: ok=%0d strb_prev=%b done=%b result=%h err=%b required 1 1 001 0f 0", ok, s, done_o, result_o, err_o);
        end
        req_i = 3'b000;
        model_p = 1;
        step();
        total = total + 1;
        if (done_o !== 3'b000 || strb_cnt != 1 || busy_o !== 1'b0 || result_o !== 8'h0F) begin
            bad = bad + 1;
            $display("FAIL single_after: done=%b strobes=%0d busy=%b result=%h required 000 1 0 0f", done_o, strb_cnt, busy_o, result_o);
        end
    endtask

    task automatic test_negative();
        bit ok;
        bit s;
        a_v[1] = 8'hFD;
        b_v[1] = 8'd5;
        req_i = 3'b010;
        wait_done(ok, s);
        total = total + 1;
        if (!ok || done_o !== 3'b010 || result_o !== 8'hF1) begin
            bad = bad + 1;
            $display("FAIL negative: ok=%0d done=%b result=%h required 1 010 f1", ok, done_o, result_o);
        end
        req_i = 3'b000;
        model_p = 2;
        step();
    endtask

    task automatic test_round_robin();
        bit ok;
        bit s;
        int order_a [3] = '{0, 1, 2};
        int order_b [3] = '{1, 2, 0};
        logic [2:0] exp_oh;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a_v[k] = 8'($urandom);
            b_v[k] = 8'($urandom);
        end
        req_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_done(ok, s);
            exp_oh = 3'b000;
            exp_oh[order_a[i]] = 1'b1;
            total = total + 1;
            if (!ok || done_o !== exp_oh || result_o !== model_prod(a_v[order_a[i]], b_v[order_a[i]])) begin
                bad = bad + 1;
                $display("FAIL rr_from_p0[%0d]: ok=%0d done=%b result=%h required %b %h", i, ok, done_o, result_o, exp_oh, model_prod(a_v[order_a[i]], b_v[order_a[i]]));
            end
            req_i[order_a[i]] = 1'b0;
        end
        req_i = 3'b001;
        wait_done(ok, s);
        req_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_done(ok, s);
            exp_oh = 3'b000;
            exp_oh[order_b[i]] = 1'b1;
            total = total + 1;
            if (!ok || done_o !== exp_oh || result_o !== model_prod(a_v[order_b[i]], b_v[order_b[i]])) begin
                bad = bad + 1;
                $display("FAIL rr_from_p1[%0d]: ok=%0d done=%b result=%h required %b %h", i, ok, done_o, result_o, exp_oh, model_prod(a_v[order_b[i]], b_v[order_b[i]]));
            end
            req_i[order_b[i]] = 1'b0;
        end
        model_p = 1;
        step();
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        mul_en = 1'b0;
        a_v[2] = 8'd9;
        b_v[2] = 8'd9;
        req_i = 3'b100;
        step();
        // Strobe seen: WAIT starts next edge; abort lands 32 edges later.
        for (int i = 0; i < 32; i++) begin
            step();
            if (done_o !== 3'b000 || err_o !== 1'b0) early = 1'b1;
        end
        total = total + 1;
        if (early) begin
            bad = bad + 1;
            $display("FAIL timeout_early: done/err pulsed before 32 WAIT cycles, required none");
        end
        step();
        total = total + 1;
        if (done_o !== 3'b100 || err_o !== 1'b1 || result_o !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL timeout_abort: done=%b err=%b result=%h required 100 1 00", done_o, err_o, result_o);
        end
        req_i = 3'b000;
        mul_en = 1'b1;
        model_p = 0;
        step();
        total = total + 1;
        if (err_o !== 1'b0 || done_o !== 3'b000 || busy_o !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL timeout_after: err=%b done=%b busy=%b required 0 000 0", err_o, done_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        bit leak;
        leak = 1'b0;
        a_v[0] = 8'd4;
        b_v[0] = 8'd6;
        req_i = 3'b001;
        step();
        for (int i = 0; i < 5; i++) step();
        rst_i = 1'b1;
        req_i = 3'b000;
        step();
        rst_i = 1'b0;
        model_p = 0;
        total = total + 1;
        if ({done_o, err_o, busy_o, mul_start_strb_o} !== 6'b0 || {result_o, mul_a_o, mul_b_o} !== 24'h0) begin
            bad = bad + 1;
            $display("FAIL reset_mid_state: done=%b err=%b busy=%b strb=%b result=%h a=%h b=%h required all 0", done_o, err_o, busy_o, mul_start_strb_o, result_o, mul_a_o, mul_b_o);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (done_o !== 3'b000 || busy_o !== 1'b0 || result_o !== 8'h00) leak = 1'b1;
        end
        total = total + 1;
        if (leak) begin
            bad = bad + 1;
            $display("FAIL reset_mid_late_strobe: stray done/busy/result after reset, required none");
        end
    endtask

    task automatic test_operand_hold();
        bit ok;
        bit s;
        a_v[0] = 8'd7;
        b_v[0] = 8'hFE;
        req_i = 3'b001;
        step();
        for (int i = 0; i < 3; i++) step();
        a_v[0] = 8'd1;
        b_v[0] = 8'd1;
        step();
        total = total + 1;
        if (mul_a_o !== 8'd7 || mul_b_o !== 8'hFE) begin
            bad = bad + 1;
            $display("FAIL operand_hold: a=%h b=%h required 07 fe", mul_a_o, mul_b_o);
        end
        wait_done(ok, s);
        total = total + 1;
        if (!ok || done_o !== 3'b001 || result_o !== model_prod(8'd7, 8'hFE)) begin
            bad = bad + 1;
            $display("FAIL operand_hold_result: ok=%0d done=%b result=%h required 001 %h", ok, done_o, result_o, model_prod(8'd7, 8'hFE));
        end
        req_i = 3'b000;
        model_p = 1;
        step();
    endtask

    task automatic test_random();
        bit ok;
        bit s;
        int g;
        logic [2:0] exp_oh;
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 3; k++) begin
                a_v[k] = 8'($urandom);
                b_v[k] = 8'($urandom);
            end
            req_i = 3'($urandom_range(1, 7));
            while (req_i != 3'b000) begin
                wait_done(ok, s);
                g = model_grant(req_i, model_p);
                exp_oh = 3'b000;
                exp_oh[g] = 1'b1;
                total = total + 1;
                if (!ok || done_o !== exp_oh || err_o !== 1'b0 || result_o !== model_prod(a_v[g], b_v[g])) begin
                    bad = bad + 1;
                    $display("FAIL random[%0d]: ok=%0d done=%b err=%b result=%h required %b 0 %h", r, ok, done_o, err_o, result_o, exp_oh, model_prod(a_v[g], b_v[g]));
                end
                if (!ok) req_i = 3'b000;
                else req_i[g] = 1'b0;
                model_p = (g + 1) % 3;
            end
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) step();
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            a_v[k] = 8'h00;
            b_v[k] = 8'h00;
        end
        test_reset();
        test_single();
        test_negative();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_operand_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
